// File: rtl/fetch_ifid_stage_pkg.sv
// Shared definitions for the IF stage and IF/ID register:
// fetch FSM states and instruction field positions.
package fetch_ifid_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_e;

    localparam int IMM_LSB = 0;

endpackage

// File: rtl/fetch_ifid_stage_pc_register.sv
// Program counter: async-reset register with load enable,
// reset value supplied by the enclosing stage.
module pc_register #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RESET_VAL;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/fetch_ifid_stage.sv
// IF stage with variable-latency imem handshake, stall/redirect
// handling and the IF/ID pipeline register.
module fetch_ifid_stage
    import fetch_ifid_stage_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               IMM_W    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [WIDTH-1:0] RedirectPC,
    output logic             ImemReq,
    output logic [WIDTH-1:0] ImemAddr,
    input  logic [WIDTH-1:0] ImemRdata,
    input  logic             ImemValid,
    output logic             IfIdValid,
    output logic [WIDTH-1:0] IfIdInstr,
    output logic [WIDTH-1:0] IfIdPCPlus4,
    output logic [IMM_W-1:0] IfIdImm16
);

    fetch_state_e     state, state_nxt;
    logic [WIDTH-1:0] pc, pc_d, pc_plus4, redir_pc;
    logic [WIDTH-1:0] req_addr, hold_instr, take_data;
    logic             pc_load, take, squash, bubble, hold_load;
    logic             unused_redir_lsbs;

    assign redir_pc          = {RedirectPC[WIDTH-1:2], 2'b00};
    assign unused_redir_lsbs = ^RedirectPC[1:0];
    assign pc_plus4          = pc + WIDTH'(4);

    pc_register #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk  (Clk),
        .rst  (Reset),
        .load (pc_load),
        .d    (pc_d),
        .q    (pc)
    );

    always_comb begin
        state_nxt = state;
        pc_load   = 1'b0;
        pc_d      = pc;
        take      = 1'b0;
        take_data = hold_instr;
        squash    = 1'b0;
        bubble    = 1'b0;
        hold_load = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (Redirect) begin
                    squash    = 1'b1;
                    pc_load   = 1'b1;
                    pc_d      = redir_pc;
                    state_nxt = ImemValid ? S_FETCH : S_DROP;
                end else if (ImemValid && !Stall) begin
                    take      = 1'b1;
                    take_data = ImemRdata;
                    pc_load   = 1'b1;
                    pc_d      = pc_plus4;
                end else if (ImemValid) begin
                    hold_load = 1'b1;
                    state_nxt = S_HOLD;
                end else if (!Stall) begin
                    bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (Redirect) begin
                    squash    = 1'b1;
                    pc_load   = 1'b1;
                    pc_d      = redir_pc;
                    state_nxt = S_FETCH;
                end else if (!Stall) begin
                    take      = 1'b1;
                    pc_load   = 1'b1;
                    pc_d      = pc_plus4;
                    state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                if (Redirect) begin
                    squash  = 1'b1;
                    pc_load = 1'b1;
                    pc_d    = redir_pc;
                end else if (!Stall) begin
                    bubble = 1'b1;
                end
                if (ImemValid)
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // req_addr freezes in DROP so the abandoned request stays stable
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            ImemReq     <= 1'b0;
            req_addr    <= RESET_PC;
            hold_instr  <= '0;
            IfIdValid   <= 1'b0;
            IfIdInstr   <= '0;
            IfIdPCPlus4 <= '0;
        end else begin
            state   <= state_nxt;
            ImemReq <= (state_nxt == S_FETCH) || (state_nxt == S_DROP);
            if (state_nxt != S_DROP)
                req_addr <= pc_d;
            if (hold_load)
                hold_instr <= ImemRdata;
            if (squash || bubble) begin
                IfIdValid <= 1'b0;
                IfIdInstr <= '0;
            end else if (take) begin
                IfIdValid   <= 1'b1;
                IfIdInstr   <= take_data;
                IfIdPCPlus4 <= pc_plus4;
            end
        end
    end

    assign ImemAddr  = req_addr;
    assign IfIdImm16 = IfIdInstr[IMM_LSB +: IMM_W];

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed and randomized checks of fetch_ifid_stage against an
// instruction-stream reference model and a latency-randomized memory.
module tb_fetch_ifid_stage;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Redirect, ImemValid;
    logic [31:0] RedirectPC, ImemRdata;
    logic        ImemReq, IfIdValid;
    logic [31:0] ImemAddr, IfIdInstr, IfIdPCPlus4;
    logic [15:0] IfIdImm16;

    int passes = 0;
    int total  = 0;

    fetch_ifid_stage dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Stall       (Stall),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemRdata   (ImemRdata),
        .ImemValid   (ImemValid),
        .IfIdValid   (IfIdValid),
        .IfIdInstr   (IfIdInstr),
        .IfIdPCPlus4 (IfIdPCPlus4),
        .IfIdImm16   (IfIdImm16)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({a[31:2], 2'b00} ^ 32'h5EED_0000) * 32'h9E37_79B1 + 32'h1;
    endfunction

    // random-phase state
    logic        busy;
    int          lat;
    logic [31:0] cap_addr, exp_pc;
    logic        p_stall, p_redir, p_valid;
    logic [31:0] p_rpc, p_instr, p_pc4;
    int          deliveries;

    initial begin
        Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0;
        RedirectPC = '0; ImemValid = 1'b0; ImemRdata = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_req", ImemReq, 0);
        chk("rst_addr", ImemAddr, 0);
        chk("rst_valid", IfIdValid, 0);
        chk("rst_instr", IfIdInstr, 0);
        chk("rst_pc4", IfIdPCPlus4, 0);

        // back-to-back fetch of A, B
        Reset = 1'b0;
        step();
        chk("first_req", ImemReq, 1);
        chk("first_addr", ImemAddr, 32'h0);
        step();
        chk("req_held", ImemReq, 1);
        ImemValid = 1'b1; ImemRdata = 32'hAAAA_0001;
        step();
        ImemValid = 1'b0;
        chk("a_valid", IfIdValid, 1);
        chk("a_instr", IfIdInstr, 32'hAAAA_0001);
        chk("a_pc4", IfIdPCPlus4, 32'h4);
        chk("a_next_addr", ImemAddr, 32'h4);
        step();
        chk("gap_bubble", IfIdValid, 0);
        ImemValid = 1'b1; ImemRdata = 32'hBBBB_0002;
        step();
        ImemValid = 1'b0;
        chk("b_instr", IfIdInstr, 32'hBBBB_0002);
        chk("b_pc4", IfIdPCPlus4, 32'h8);
        chk("b_next_addr", ImemAddr, 32'h8);

        // data arrives under stall -> held until stall drops
        Stall = 1'b1; ImemValid = 1'b1; ImemRdata = 32'hCCCC_0003;
        step();
        ImemValid = 1'b0;
        chk("hold_req", ImemReq, 0);
        chk("hold_instr", IfIdInstr, 32'hBBBB_0002);
        chk("hold_pc4", IfIdPCPlus4, 32'h8);
        step();
        chk("hold2_instr", IfIdInstr, 32'hBBBB_0002);
        Stall = 1'b0;
        step();
        chk("unhold_instr", IfIdInstr, 32'hCCCC_0003);
        chk("unhold_pc4", IfIdPCPlus4, 32'hC);
        chk("unhold_req", ImemReq, 1);
        chk("unhold_addr", ImemAddr, 32'hC);

        // redirect with request pending -> drop old response
        Redirect = 1'b1; RedirectPC = 32'h0000_0103;
        step();
        Redirect = 1'b0;
        chk("drop_squash", IfIdValid, 0);
        chk("drop_instr", IfIdInstr, 0);
        chk("drop_req", ImemReq, 1);
        chk("drop_old_addr", ImemAddr, 32'hC);
        ImemValid = 1'b1; ImemRdata = 32'hDEAD_BEEF;
        step();
        ImemValid = 1'b0;
        chk("drop_new_addr", ImemAddr, 32'h100);
        chk("drop_discard", IfIdValid, 0);

        // redirect + stall + valid together
        Redirect = 1'b1; Stall = 1'b1; RedirectPC = 32'h200;
        ImemValid = 1'b1; ImemRdata = 32'h1111_1111;
        step();
        Redirect = 1'b0; Stall = 1'b0; ImemValid = 1'b0;
        chk("rs_addr", ImemAddr, 32'h200);
        chk("rs_req", ImemReq, 1);
        chk("rs_bubble", IfIdValid, 0);
        chk("rs_instr", IfIdInstr, 0);

        // wrap at top of address space
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0; ImemValid = 1'b1;
        step();
        chk("wrap_addr", ImemAddr, 32'hFFFF_FFFC);
        ImemRdata = 32'h2008_FFFF;
        step();
        ImemValid = 1'b0;
        chk("wrap_pc4", IfIdPCPlus4, 32'h0);
        chk("wrap_next", ImemAddr, 32'h0);
        chk("imm_instr", IfIdInstr, 32'h2008_FFFF);
        chk("imm16", {16'h0, IfIdImm16}, 32'h0000_FFFF);

        // async reset mid-request, stray valid ignored
        step();
        #2;
        Reset = 1'b1;
        #1;
        chk("ar_req", ImemReq, 0);
        chk("ar_valid", IfIdValid, 0);
        chk("ar_instr", IfIdInstr, 0);
        chk("ar_pc4", IfIdPCPlus4, 0);
        ImemValid = 1'b1; ImemRdata = 32'h7777_7777;
        #1;
        Reset = 1'b0;
        step();
        ImemValid = 1'b0;
        chk("stray_valid", IfIdValid, 0);
        chk("stray_instr", IfIdInstr, 0);
        chk("stray_req", ImemReq, 1);
        chk("stray_addr", ImemAddr, 32'h0);

        // random phase: stream model + latency-randomized memory
        busy = 1'b0; lat = 0; cap_addr = '0;
        exp_pc = 32'h0; deliveries = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!busy && ImemReq) begin
                busy = 1'b1;
                cap_addr = ImemAddr;
                lat = int'($urandom_range(0, 2));
            end
            ImemValid = 1'b0;
            if (busy) begin
                chk("rnd_req_held", ImemReq, 1);
                chk("rnd_addr_stable", ImemAddr, cap_addr);
                if (lat == 0) begin
                    ImemValid = 1'b1;
                    ImemRdata = mem_word(cap_addr);
                    busy = 1'b0;
                end else begin
                    lat--;
                end
            end
            Stall = ($urandom_range(0, 3) == 0);
            Redirect = ($urandom_range(0, 19) == 0);
            RedirectPC = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 | $urandom_range(0, 7)
                                                       : $urandom;
            p_stall = Stall; p_redir = Redirect; p_rpc = RedirectPC;
            p_valid = IfIdValid; p_instr = IfIdInstr; p_pc4 = IfIdPCPlus4;
            step();
            if (p_redir) begin
                exp_pc = {p_rpc[31:2], 2'b00};
                chk("rnd_squash_v", IfIdValid, 0);
                chk("rnd_squash_i", IfIdInstr, 0);
            end else if (p_stall) begin
                chk("rnd_stall_v", IfIdValid, p_valid);
                chk("rnd_stall_i", IfIdInstr, p_instr);
                chk("rnd_stall_p", IfIdPCPlus4, p_pc4);
            end else if (IfIdValid) begin
                chk("rnd_instr", IfIdInstr, mem_word(exp_pc));
                chk("rnd_pc4", IfIdPCPlus4, exp_pc + 32'h4);
                chk("rnd_imm", {16'h0, IfIdImm16},
                    {16'h0, mem_word(exp_pc) & 32'hFFFF});
                exp_pc = exp_pc + 32'h4;
                deliveries++;
            end else begin
                chk("rnd_bubble_i", IfIdInstr, 0);
            end
        end
        chk("rnd_progress", 32'(deliveries >= 100), 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
